// File: rtl/brightness_pkg.sv
// brightness_pkg: shared types and elaboration helpers for brightness_ramp_filter.
//   MAXV     full-scale value of the default 8-bit channel
//   mode_e   per-pixel modulation mode (additive / multiplicative)
//   pixel_t  unpacked per-channel pixel view for the default geometry
//   maxv_of  full-scale value for an arbitrary channel width
//   recip    fixed-point (Q16) scale mapping MAX_BPM onto full scale
package brightness_pkg;

    localparam int unsigned DEF_BITS     = 8;
    localparam int unsigned DEF_CHANNELS = 3;
    localparam int unsigned MAXV         = (1 << DEF_BITS) - 1;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_MUL = 1'b1
    } mode_e;

    typedef logic [DEF_BITS-1:0] pixel_t [DEF_CHANNELS];

    function automatic int unsigned maxv_of(input int unsigned bits);
        return (1 << bits) - 1;
    endfunction

    // round(2**16 * maxv / max_bpm), computed with round-half-up integer division
    function automatic int unsigned recip(input int unsigned bits, input int unsigned max_bpm);
        longint unsigned num;
        num = (64'(maxv_of(bits)) << 16) + 64'(max_bpm / 2);
        return 32'(num / 64'(max_bpm));
    endfunction

endpackage

// File: rtl/bright_level_ramp.sv
// bright_level_ramp: maps a BPM estimate to a target brightness and slews the applied
// level toward it by at most RAMP_STEP every RAMP_DIV clock cycles.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high
//   bpm    in   heart-rate estimate
//   level  out  currently applied brightness level
module bright_level_ramp
    import brightness_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned MAX_BPM   = 200,
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned RAMP_DIV  = 1024,
    parameter int unsigned BPM_W     = $clog2(MAX_BPM + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm,
    output logic [BITS-1:0]  level
);

    localparam int unsigned   MAXV_I    = maxv_of(BITS);
    localparam logic [31:0]   RECIP     = 32'(recip(BITS, MAX_BPM));
    localparam logic [BPM_W-1:0] MAX_BPM_C = BPM_W'(MAX_BPM);
    localparam int unsigned   STEP_SAT  = (RAMP_STEP > MAXV_I) ? MAXV_I : RAMP_STEP;
    localparam logic [BITS-1:0] STEP_C  = BITS'(STEP_SAT);
    localparam int unsigned   CW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(RAMP_DIV - 1);

    logic [BITS-1:0] target;
    logic [BITS-1:0] scaled;
    logic [CW-1:0]   cnt_q;
    logic            tick;
    logic [BITS-1:0] level_q, level_d;

    // Below MAX_BPM the Q16 product always fits in BITS bits after the shift.
    assign scaled = BITS'((64'(bpm) * 64'(RECIP)) >> 16);
    assign target = (bpm >= MAX_BPM_C) ? BITS'(MAXV_I) : scaled;

    assign tick = (cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        if (RAMP_STEP == 0) begin
            level_d = target;
        end else if (tick) begin
            // Clamp the last step to the remaining distance so the level never overshoots.
            if (level_q < target) begin
                level_d = ((target - level_q) > STEP_C) ? level_q + STEP_C : target;
            end else if (level_q > target) begin
                level_d = ((level_q - target) > STEP_C) ? level_q - STEP_C : target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/brightness_ramp_filter.sv
// brightness_ramp_filter: multi-channel pixel filter between a frame source and a VGA sink.
// A BPM-driven brightness level (slew-limited) is added (saturating) to or multiplied into
// every channel of each pixel. Two-stage valid/ready pipeline with full backpressure.
// Optional feature macro: BRIGHT_SAT_STATS_EN adds sat_count / sat_clear.
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high
//   pix_in         in   input pixel, channel 0 at LSBs
//   valid_in       in   pix_in valid
//   output_ready   out  block accepts pix_in this cycle
//   pix_out        out  filtered pixel
//   valid_out      out  pix_out valid
//   module_ready   in   downstream accepts pix_out this cycle
//   filter_enable  in   0 = transparent, 1 = apply level
//   mode           in   0 = additive, 1 = multiplicative
//   BPM_estimate   in   heart-rate estimate
//   brightness     out  currently applied level
//   sat_count      out  (BRIGHT_SAT_STATS_EN) output pixels clamped in additive mode
//   sat_clear      in   (BRIGHT_SAT_STATS_EN) synchronous clear of sat_count
module brightness_ramp_filter
    import brightness_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned MAX_BPM   = 200,
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned RAMP_DIV  = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS*BITS-1:0]        pix_in,
    input  logic                            valid_in,
    output logic                            output_ready,
    output logic [CHANNELS*BITS-1:0]        pix_out,
    output logic                            valid_out,
    input  logic                            module_ready,
    input  logic                            filter_enable,
    input  logic                            mode,
    input  logic [$clog2(MAX_BPM+1)-1:0]    BPM_estimate,
    output logic [BITS-1:0]                 brightness
`ifdef BRIGHT_SAT_STATS_EN
    ,
    output logic [15:0]                     sat_count,
    input  logic                            sat_clear
`endif
);

    localparam int unsigned     W      = CHANNELS * BITS;
    localparam logic [BITS-1:0] MAXV_C = BITS'(maxv_of(BITS));

    logic [BITS-1:0] level;

    bright_level_ramp #(
        .BITS      (BITS),
        .MAX_BPM   (MAX_BPM),
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV),
        .BPM_W     ($clog2(MAX_BPM + 1))
    ) u_ramp (
        .clk   (clk),
        .reset (reset),
        .bpm   (BPM_estimate),
        .level (level)
    );

    assign brightness = level;

    // Stage 1: captured pixel plus the controls in force when it was accepted.
    logic            s1_valid_q;
    logic [W-1:0]    s1_pix_q;
    logic            s1_en_q;
    mode_e           s1_mode_q;
    logic [BITS-1:0] s1_level_q;

    // Stage 2: computed output.
    logic            s2_valid_q;
    logic [W-1:0]    s2_pix_q;

    logic            adv2;
    logic [W-1:0]    comp_pix;

    assign adv2         = !s2_valid_q || module_ready;
    assign output_ready = !s1_valid_q || adv2;

`ifdef BRIGHT_SAT_STATS_EN
    logic [CHANNELS-1:0] clamp;
    logic                s2_sat_q;
    logic [15:0]         sat_cnt_q;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [BITS-1:0]   ch_in;
        logic [BITS-1:0]   ch_out;
        logic [BITS:0]     sum;
        logic [2*BITS:0]   prod;

        assign ch_in = s1_pix_q[c*BITS +: BITS];
        assign sum   = {1'b0, ch_in} + {1'b0, s1_level_q};
        // level+1 so that full-scale level multiplies by exactly 1.0
        assign prod  = (2*BITS+1)'(ch_in) * (2*BITS+1)'({1'b0, s1_level_q} + 1'b1);

        always_comb begin
            ch_out = ch_in;
            if (s1_en_q) begin
                if (s1_mode_q == MODE_ADD) begin
                    ch_out = sum[BITS] ? MAXV_C : sum[BITS-1:0];
                end else begin
                    ch_out = BITS'(prod >> BITS);
                end
            end
        end

        assign comp_pix[c*BITS +: BITS] = ch_out;

`ifdef BRIGHT_SAT_STATS_EN
        assign clamp[c] = s1_en_q && (s1_mode_q == MODE_ADD) && sum[BITS];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_en_q    <= 1'b0;
            s1_mode_q  <= MODE_ADD;
            s1_level_q <= '0;
            s2_valid_q <= 1'b0;
            s2_pix_q   <= '0;
        end else begin
            if (output_ready) begin
                s1_valid_q <= valid_in;
                if (valid_in) begin
                    s1_pix_q   <= pix_in;
                    s1_en_q    <= filter_enable;
                    s1_mode_q  <= mode_e'(mode);
                    s1_level_q <= level;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_pix_q <= comp_pix;
                end
            end
        end
    end

    assign pix_out   = s2_pix_q;
    assign valid_out = s2_valid_q;

`ifdef BRIGHT_SAT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_sat_q <= 1'b0;
        end else if (adv2 && s1_valid_q) begin
            s2_sat_q <= |clamp;
        end
    end

    // Clear takes priority over an increment in the same cycle; count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || sat_clear) begin
            sat_cnt_q <= '0;
        end else if (s2_valid_q && module_ready && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_brightness_ramp_filter.sv
// Self-checking bench for brightness_ramp_filter (BITS=8, 3 channels, MAX_BPM=200,
// RAMP_STEP=4, RAMP_DIV=4). Accepted pixels push their expected output into a queue;
// a negedge monitor pops and compares on every output transfer and checks hold stability.
module tb_brightness_ramp_filter;

    localparam int unsigned BITS = 8;
    localparam int unsigned CH   = 3;
    localparam int unsigned W    = BITS * CH;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  pix_in;
    logic          valid_in;
    logic          output_ready;
    logic [W-1:0]  pix_out;
    logic          valid_out;
    logic          module_ready;
    logic          filter_enable;
    logic          mode;
    logic [7:0]    bpm;
    logic [7:0]    brightness;
`ifdef BRIGHT_SAT_STATS_EN
    logic [15:0]   sat_count;
    logic          sat_clear;
`endif

    always #5 clk = ~clk;

    brightness_ramp_filter #(
        .BITS      (BITS),
        .CHANNELS  (CH),
        .MAX_BPM   (200),
        .RAMP_STEP (4),
        .RAMP_DIV  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pix_in        (pix_in),
        .valid_in      (valid_in),
        .output_ready  (output_ready),
        .pix_out       (pix_out),
        .valid_out     (valid_out),
        .module_ready  (module_ready),
        .filter_enable (filter_enable),
        .mode          (mode),
        .BPM_estimate  (bpm),
        .brightness    (brightness)
`ifdef BRIGHT_SAT_STATS_EN
        ,
        .sat_count     (sat_count),
        .sat_clear     (sat_clear)
`endif
    );

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_pix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pk(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // Scoreboard monitor: sample away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 32'(valid_out), 32'd1);
                    check("hold_pix", 32'(pix_out), 32'(hold_pix));
                end
                hold_pending = valid_out && !module_ready;
                hold_pix     = pix_out;
                if (valid_out && module_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'(valid_out), 32'd0);
                    end else begin
                        check("pix_out", 32'(pix_out), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Presents one pixel until accepted; expected value enters the queue on acceptance.
    task automatic send(input logic [W-1:0] p, input logic [W-1:0] e);
        pix_in   = p;
        valid_in = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (output_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 32'(output_ready), 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int tgt);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (brightness == 8'(tgt)) break;
        end
        check("level_settle", 32'(brightness), 32'(tgt));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
        cycles(2);
    endtask

    // Follows the ramp: every change is one clamped step, changes are 4 cycles apart.
    task automatic watch_ramp(input int tgt);
        int prev;
        int last;
        int expv;
        bit done;
        @(negedge clk);
        prev = int'(brightness);
        last = -1;
        done = 0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            if (int'(brightness) != prev) begin
                if (prev < tgt) expv = prev + ((tgt - prev) > 4 ? 4 : (tgt - prev));
                else            expv = prev - ((prev - tgt) > 4 ? 4 : (prev - tgt));
                check("ramp_step", 32'(brightness), 32'(expv));
                if (last >= 0) check("ramp_interval", 32'(cyc - last), 32'd4);
                prev = int'(brightness);
                last = cyc;
                if (prev == tgt) done = 1;
            end
        end
        check("ramp_reached", 32'(brightness), 32'(tgt));
        repeat (12) @(negedge clk);
        check("ramp_hold", 32'(brightness), 32'(tgt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        pix_in        = '0;
        valid_in      = 1'b0;
        module_ready  = 1'b1;
        filter_enable = 1'b0;
        mode          = 1'b0;
        bpm           = 8'd0;
`ifdef BRIGHT_SAT_STATS_EN
        sat_clear     = 1'b0;
`endif
        cycles(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_brightness", 32'(brightness), 32'd0);
        check("rst_output_ready", 32'(output_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: bypass with exact two-cycle latency and single-cycle valid
        bpm = 8'd100;
        filter_enable = 1'b0;
        send(pk(50, 100, 150), pk(50, 100, 150));
        valid_in = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(valid_out), 32'd1);
        @(negedge clk);
        check("lat_cycle3_valid", 32'(valid_out), 32'd0);
        drain();

        // 2: additive
        bpm = 8'd50;
        wait_level(63);
        filter_enable = 1'b1;
        mode = 1'b0;
        send(pk(0, 150, 200), pk(63, 213, 255));
        valid_in = 1'b0;
        bpm = 8'd100;
        wait_level(127);
        send(pk(128, 128, 128), pk(255, 255, 255));
        send(pk(10, 128, 100), pk(137, 255, 227));
        valid_in = 1'b0;
        drain();

        // 3: multiplicative
        mode = 1'b1;
        send(pk(200, 200, 200), pk(100, 100, 100));
        send(pk(0, 255, 1), pk(0, 127, 0));
        valid_in = 1'b0;
        bpm = 8'd200;
        wait_level(255);
        send(pk(77, 77, 77), pk(77, 77, 77));
        valid_in = 1'b0;
        drain();

        // 4: ramp up to 127, then down to 0
        bpm = 8'd0;
        wait_level(0);
        bpm = 8'd100;
        watch_ramp(127);
        bpm = 8'd0;
        watch_ramp(0);

        // 5: backpressure mid-stream (bypass)
        filter_enable = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(pk(i * 20, i * 20 + 1, i * 20 + 2), pk(i * 20, i * 20 + 1, i * 20 + 2));
                end
                valid_in = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                module_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_output_ready", 32'(output_ready), 32'd0);
                @(posedge clk);
                @(posedge clk);
                #2;
                module_ready = 1'b1;
            end
        join
        drain();

        // 6: reset with two pixels in flight
        bpm = 8'd100;
        cycles(20);
        module_ready = 1'b0;
        send(pk(1, 2, 3), pk(1, 2, 3));
        send(pk(4, 5, 6), pk(4, 5, 6));
        valid_in = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_out", 32'(valid_out), 32'd0);
        check("mid_rst_pix_out", 32'(pix_out), 32'd0);
        check("mid_rst_brightness", 32'(brightness), 32'd0);
        check("mid_rst_output_ready", 32'(output_ready), 32'd1);
        @(posedge clk);
        #1;
        module_ready = 1'b1;
        cycles(6);
        send(pk(9, 8, 7), pk(9, 8, 7));
        valid_in = 1'b0;
        drain();

`ifdef BRIGHT_SAT_STATS_EN
        check("sat_after_reset", 32'(sat_count), 32'd0);
        bpm = 8'd200;
        filter_enable = 1'b1;
        mode = 1'b0;
        wait_level(255);
        for (int i = 0; i < 3; i++) send(pk(1, 0, 0), pk(255, 255, 255));
        send(pk(0, 0, 0), pk(255, 255, 255));
        valid_in = 1'b0;
        drain();
        check("sat_count_3", 32'(sat_count), 32'd3);
        sat_clear = 1'b1;
        cycles(1);
        sat_clear = 1'b0;
        @(negedge clk);
        check("sat_cleared", 32'(sat_count), 32'd0);
        for (int i = 0; i < 65540; i++) send(pk(5, 5, 5), pk(255, 255, 255));
        valid_in = 1'b0;
        drain();
        check("sat_saturated", 32'(sat_count), 32'hFFFF);
`endif

        cycles(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
